// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, issues one memory access, returns
// one tagged response. Define LSU_BOUNDS_CHECK_EN to reject addresses >= MEM_BYTES.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Request
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_tag,
  // Memory port
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  // Response
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic [4:0]  o_resp_tag,
  output logic        o_resp_err,
  output logic [1:0]  o_resp_err_code
);

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;
  localparam logic [1:0] SizeBad = 2'd3;

  localparam logic [1:0] WrN = 2'd0;
  localparam logic [1:0] WrB = 2'd1;
  localparam logic [1:0] WrH = 2'd2;
  localparam logic [1:0] WrW = 2'd3;

  localparam logic [2:0] RdW  = 3'd0;
  localparam logic [2:0] RdHz = 3'd1;
  localparam logic [2:0] RdBz = 3'd2;
  localparam logic [2:0] RdHe = 3'd3;
  localparam logic [2:0] RdBe = 3'd4;
  localparam logic [2:0] RdXx = 3'd5;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrAlign = 2'd1;
  localparam logic [1:0] ErrRange = 2'd2;
  localparam logic [1:0] ErrSize  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [4:0]  tag_q, tag_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_tag_q, resp_tag_d;
  logic        resp_err_q, resp_err_d;
  logic [1:0]  resp_code_q, resp_code_d;

  logic [1:0]  req_err_code;

  // Error classification in priority order: size, alignment, range.
  always_comb begin
    req_err_code = ErrNone;
    if (i_req_size == SizeBad) begin
      req_err_code = ErrSize;
    end else if ((i_req_size == SizeH && i_req_addr[0]) ||
                 (i_req_size == SizeW && i_req_addr[1:0] != 2'b00)) begin
      req_err_code = ErrAlign;
`ifdef LSU_BOUNDS_CHECK_EN
    end else if (i_req_addr >= 32'(MEM_BYTES)) begin
      req_err_code = ErrRange;
`endif
    end
  end

`ifndef LSU_BOUNDS_CHECK_EN
  logic unused_mem_bytes;
  assign unused_mem_bytes = ^32'(MEM_BYTES);
`endif

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    signed_d    = signed_q;
    tag_d       = tag_q;
    err_code_d  = err_code_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    resp_err_d  = resp_err_q;
    resp_code_d = resp_code_q;

    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          store_d    = i_req_store;
          size_d     = i_req_size;
          signed_d   = i_req_signed;
          tag_d      = i_req_tag;
          err_code_d = req_err_code;
          // Memory-side registers only move for requests that will really be issued.
          if (req_err_code == ErrNone) begin
            mem_addr_d  = i_req_addr;
            mem_wdata_d = i_req_wdata;
            state_d     = StIssue;
          end else begin
            // Errors skip ISSUE but take the WAIT slot, so no memory access happens.
            state_d = StWait;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        resp_tag_d  = tag_q;
        resp_err_d  = (err_code_q != ErrNone);
        resp_code_d = err_code_q;
        resp_data_d = (store_q || err_code_q != ErrNone) ? 32'h0 : i_mem_rd_data;
        state_d     = StResp;
      end
      StResp: begin
        if (i_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset low masks the strobes immediately, so an ISSUE cycle caught by reset never writes.
  always_comb begin
    o_mem_wr_mask = WrN;
    o_mem_rd_mask = RdXx;
    if (i_reset && state_q == StIssue) begin
      if (store_q) begin
        unique case (size_q)
          SizeB:   o_mem_wr_mask = WrB;
          SizeH:   o_mem_wr_mask = WrH;
          SizeW:   o_mem_wr_mask = WrW;
          default: o_mem_wr_mask = WrN;
        endcase
      end else begin
        unique case (size_q)
          SizeB:   o_mem_rd_mask = signed_q ? RdBe : RdBz;
          SizeH:   o_mem_rd_mask = signed_q ? RdHe : RdHz;
          SizeW:   o_mem_rd_mask = RdW;
          default: o_mem_rd_mask = RdXx;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      tag_q       <= 5'd0;
      err_code_q  <= ErrNone;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      resp_data_q <= 32'h0;
      resp_tag_q  <= 5'd0;
      resp_err_q  <= 1'b0;
      resp_code_q <= ErrNone;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      tag_q       <= tag_d;
      err_code_q  <= err_code_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
      resp_err_q  <= resp_err_d;
      resp_code_q <= resp_code_d;
    end
  end

  assign o_req_ready     = (state_q == StIdle);
  assign o_resp_valid    = (state_q == StResp);
  assign o_resp_data     = resp_data_q;
  assign o_resp_tag      = resp_tag_q;
  assign o_resp_err      = resp_err_q;
  assign o_resp_err_code = resp_code_q;
  assign o_mem_address   = mem_addr_q;
  assign o_mem_wr_data   = mem_wdata_q;

endmodule
